// File: rtl/sn_rd_ctrl.sv
// Read-response sequencer for the SN slave network interface.
// Tracks source ID and burst length of each accepted AR in an in-order FIFO,
// gates the AXI AR/R handshakes against it, and tags R flits with
// head/tail/target ID. Control only; payload buses bypass this block.
module sn_rd_ctrl #(
  parameter int DEPTH = 4,
  parameter int LEN_W = 8,
  parameter int SRC_W = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ar_valid,
  output logic             ar_ready,
  input  logic [LEN_W-1:0] ar_len,
  input  logic [SRC_W-1:0] ar_srcid,
  output logic             ARVALID,
  input  logic             ARREADY,
  input  logic             RVALID,
  output logic             RREADY,
  input  logic             RLAST,
  output logic             r_valid,
  input  logic             r_ready,
  output logic             r_head,
  output logic             r_tail,
  output logic [SRC_W-1:0] r_tgtid,
  output logic [CNT_W-1:0] outstanding,
  output logic             err_rlast
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LEN_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  logic [SRC_W-1:0] src_mem_q [DEPTH];
  logic [LEN_W-1:0] len_mem_q [DEPTH];

  logic             full, empty, push, beat, pop, tail_hit;
  logic [SRC_W-1:0] h_src;
  logic [LEN_W-1:0] h_len;

  // Tracker slots: each entry loads when the write pointer selects it on a push
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
    // Capture {srcid, len} into slot gi on an accepted AR
    always_ff @(posedge clk) begin
      if (push && (wr_ptr_q == PTR_W'(gi))) begin
        src_mem_q[gi] <= ar_srcid;
        len_mem_q[gi] <= ar_len;
      end
    end
  end

  // Handshake gating and flit tagging; full/empty come from registered count only
  always_comb begin
    full     = (cnt_q == CNT_W'(DEPTH));
    empty    = (cnt_q == '0);
    h_src    = src_mem_q[rd_ptr_q];
    h_len    = len_mem_q[rd_ptr_q];
    ARVALID  = ar_valid & ~full;
    ar_ready = ARREADY & ~full;
    push     = ar_valid & ar_ready;
    r_valid  = RVALID & ~empty;
    RREADY   = r_ready & ~empty;
    beat     = RVALID & RREADY;
    tail_hit = (beat_cnt_q == h_len);
    pop      = beat & tail_hit;
    r_head   = r_valid & (beat_cnt_q == '0);
    r_tail   = r_valid & tail_hit;
    // Stale slot contents must not leak out while nothing is tracked
    r_tgtid  = empty ? '0 : h_src;
  end

  // Next-state: pointers, beat counter, outstanding count and sticky RLAST error
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    beat_cnt_d = beat_cnt_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (beat) begin
      if (tail_hit) begin
        rd_ptr_d   = rd_ptr_q + PTR_W'(1);
        beat_cnt_d = '0;
      end else begin
        beat_cnt_d = beat_cnt_q + LEN_W'(1);
      end
      // Tracked length is authoritative; a disagreeing RLAST only flags
      if (RLAST != tail_hit) begin
        err_d = 1'b1;
      end
    end
    if (push && !pop) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (pop && !push) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // State registers with synchronous reset discarding all tracked bursts
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      beat_cnt_q <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      beat_cnt_q <= beat_cnt_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
    end
  end

  assign outstanding = cnt_q;
  assign err_rlast   = err_q;

endmodule

// File: tb/tb_sn_rd_ctrl.sv
// Directed bench for sn_rd_ctrl: AR tracking, R flit tagging, full stall,
// simultaneous push/pop, RLAST error and mid-burst stall/reset.
module tb_sn_rd_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       ar_valid, ar_ready;
  logic [7:0] ar_len;
  logic [1:0] ar_srcid;
  logic       ARVALID, ARREADY;
  logic       RVALID, RREADY, RLAST;
  logic       r_valid, r_ready, r_head, r_tail;
  logic [1:0] r_tgtid;
  logic [2:0] outstanding;
  logic       err_rlast;

  int n_checks = 0;
  int n_fail   = 0;

  sn_rd_ctrl #(.DEPTH(4), .LEN_W(8), .SRC_W(2)) dut (
    .clk(clk), .rst(rst),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_len(ar_len), .ar_srcid(ar_srcid),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RVALID(RVALID), .RREADY(RREADY), .RLAST(RLAST),
    .r_valid(r_valid), .r_ready(r_ready), .r_head(r_head), .r_tail(r_tail),
    .r_tgtid(r_tgtid), .outstanding(outstanding), .err_rlast(err_rlast)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit past the next rising edge
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Accept one AR (ARREADY=1) in a single cycle
  task automatic ar_push(input int src, input int len);
    ar_valid = 1'b1; ARREADY = 1'b1;
    ar_srcid = 2'(src); ar_len = 8'(len);
    #1;
    chk("ar_ready_push", int'(ar_ready), 1);
    chk("ARVALID_push", int'(ARVALID), 1);
    tick;
    ar_valid = 1'b0;
  endtask

  // One R beat with r_ready high; checks flit tagging before the edge
  task automatic rbeat(input int eh, input int et, input int etgt, input int rlast);
    RVALID = 1'b1; r_ready = 1'b1; RLAST = rlast[0];
    #1;
    chk("r_valid", int'(r_valid), 1);
    chk("RREADY", int'(RREADY), 1);
    chk("r_head", int'(r_head), eh);
    chk("r_tail", int'(r_tail), et);
    chk("r_tgtid", int'(r_tgtid), etgt);
    tick;
    RVALID = 1'b0; RLAST = 1'b0;
  endtask

  initial begin
    rst = 1'b1; ar_valid = 1'b0; ar_len = '0; ar_srcid = '0; ARREADY = 1'b0;
    RVALID = 1'b0; RLAST = 1'b0; r_ready = 1'b0;
    tick; tick;
    rst = 1'b0;
    #1;
    // Reset state
    chk("rst_ar_ready", int'(ar_ready), 0);
    chk("rst_ARVALID", int'(ARVALID), 0);
    chk("rst_RREADY", int'(RREADY), 0);
    chk("rst_r_valid", int'(r_valid), 0);
    chk("rst_r_head", int'(r_head), 0);
    chk("rst_r_tail", int'(r_tail), 0);
    chk("rst_r_tgtid", int'(r_tgtid), 0);
    chk("rst_outstanding", int'(outstanding), 0);
    chk("rst_err", int'(err_rlast), 0);
    tick;

    // 1: single 4-beat burst from source 2
    chk("t1_out0", int'(outstanding), 0);
    ar_push(2, 3);
    #1;
    chk("t1_out1", int'(outstanding), 1);
    rbeat(1, 0, 2, 0);
    rbeat(0, 0, 2, 0);
    rbeat(0, 0, 2, 0);
    rbeat(0, 1, 2, 1);
    #1;
    chk("t1_out_end", int'(outstanding), 0);
    chk("t1_err", int'(err_rlast), 0);

    // 2: three single-beat bursts
    ar_push(0, 0);
    ar_push(1, 0);
    ar_push(3, 0);
    #1;
    chk("t2_out", int'(outstanding), 3);
    rbeat(1, 1, 0, 1);
    rbeat(1, 1, 1, 1);
    rbeat(1, 1, 3, 1);
    #1;
    chk("t2_out_end", int'(outstanding), 0);

    // 3: fill to DEPTH, fifth AR stalls until the cycle after a pop
    ar_push(1, 0);
    ar_push(2, 0);
    ar_push(3, 0);
    ar_push(0, 0);
    ar_valid = 1'b1; ARREADY = 1'b1; ar_srcid = 2'd2; ar_len = 8'd0;
    #1;
    chk("t3_full_out", int'(outstanding), 4);
    chk("t3_full_ar_ready", int'(ar_ready), 0);
    chk("t3_full_ARVALID", int'(ARVALID), 0);
    RVALID = 1'b1; r_ready = 1'b1; RLAST = 1'b1;
    #1;
    chk("t3_pop_tgt", int'(r_tgtid), 1);
    chk("t3_pop_tail", int'(r_tail), 1);
    chk("t3_stall_on_pop", int'(ar_ready), 0);
    tick;
    RVALID = 1'b0; RLAST = 1'b0;
    #1;
    chk("t3_out_after_pop", int'(outstanding), 3);
    chk("t3_ar_ready_resume", int'(ar_ready), 1);
    chk("t3_ARVALID_resume", int'(ARVALID), 1);
    tick;
    ar_valid = 1'b0;
    #1;
    chk("t3_out_refill", int'(outstanding), 4);
    rbeat(1, 1, 2, 1);
    rbeat(1, 1, 3, 1);
    rbeat(1, 1, 0, 1);
    rbeat(1, 1, 2, 1);
    #1;
    chk("t3_out_end", int'(outstanding), 0);

    // 4: push coincides with final beat of current burst
    ar_push(1, 1);
    ar_push(3, 0);
    rbeat(1, 0, 1, 0);
    ar_valid = 1'b1; ARREADY = 1'b1; ar_srcid = 2'd0; ar_len = 8'd0;
    RVALID = 1'b1; r_ready = 1'b1; RLAST = 1'b1;
    #1;
    chk("t4_out_before", int'(outstanding), 2);
    chk("t4_tail", int'(r_tail), 1);
    chk("t4_ar_ready", int'(ar_ready), 1);
    tick;
    ar_valid = 1'b0; RVALID = 1'b0; RLAST = 1'b0;
    #1;
    chk("t4_out_same", int'(outstanding), 2);
    rbeat(1, 1, 3, 1);
    rbeat(1, 1, 0, 1);
    #1;
    chk("t4_out_end", int'(outstanding), 0);

    // 5: early RLAST sets sticky error; tail still follows the counter
    ar_push(2, 2);
    rbeat(1, 0, 2, 0);
    #1;
    chk("t5_err_pre", int'(err_rlast), 0);
    rbeat(0, 0, 2, 1);
    #1;
    chk("t5_err_set", int'(err_rlast), 1);
    rbeat(0, 1, 2, 1);
    #1;
    chk("t5_err_hold", int'(err_rlast), 1);
    chk("t5_out_end", int'(outstanding), 0);

    // 6: r_ready stall mid-burst, then reset mid-burst
    ar_push(1, 3);
    rbeat(1, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      RVALID = 1'b1; r_ready = 1'b0;
      #1;
      chk("t6_stall_RREADY", int'(RREADY), 0);
      chk("t6_stall_r_valid", int'(r_valid), 1);
      chk("t6_stall_head", int'(r_head), 0);
      chk("t6_stall_tail", int'(r_tail), 0);
      chk("t6_stall_tgt", int'(r_tgtid), 1);
      tick;
    end
    rbeat(0, 0, 1, 0);
    chk("t6_err_still", int'(err_rlast), 1);
    rst = 1'b1;
    tick;
    rst = 1'b0; RVALID = 1'b1; r_ready = 1'b1;
    #1;
    chk("t6_rst_out", int'(outstanding), 0);
    chk("t6_rst_r_valid", int'(r_valid), 0);
    chk("t6_rst_RREADY", int'(RREADY), 0);
    chk("t6_rst_err", int'(err_rlast), 0);
    chk("t6_rst_tgt", int'(r_tgtid), 0);
    RVALID = 1'b0;
    tick;
    ar_push(3, 1);
    rbeat(1, 0, 3, 0);
    rbeat(0, 1, 3, 1);
    #1;
    chk("t6_out_end", int'(outstanding), 0);
    chk("t6_err_end", int'(err_rlast), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sn_rd_ctrl.md
Name: sn_rd_ctrl

Overview:
- Read-response sequencer for the SN slave network interface.
- Records source ID and burst length of every accepted AR request in an in-order tracker FIFO.
- Gates the AXI AR/R handshakes against that tracker and marks each outgoing R flit with head, tail and target ID.
- Sits between the NoC AR/R flit ports and the AXI slave. Payload buses bypass it; it carries control only.
- The AXI slave returns read bursts in AR acceptance order.

Parameters:
- DEPTH, 4, max outstanding read bursts; power of 2, >= 2
- LEN_W, 8, AXI burst-length width (ARLEN)
- SRC_W, 2, NoC source/target ID width
- CNT_W, $clog2(DEPTH+1), outstanding-count width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ar_valid  in  1  NoC AR flit valid
- ar_ready  out  1  NoC AR flit ready
- ar_len  in  LEN_W  ARLEN field decoded from ar_payload
- ar_srcid  in  SRC_W  requesting source ID
- ARVALID  out  1  AXI AR valid
- ARREADY  in  1  AXI AR ready
- RVALID  in  1  AXI R valid
- RREADY  out  1  AXI R ready
- RLAST  in  1  AXI R last
- r_valid  out  1  NoC R flit valid
- r_ready  in  1  NoC R flit ready
- r_head  out  1  first flit of burst
- r_tail  out  1  last flit of burst
- r_tgtid  out  SRC_W  destination of current R flit
- outstanding  out  CNT_W  bursts currently tracked
- err_rlast  out  1  sticky: RLAST disagreed with tracked length

Behaviour:
- Reset (synchronous, active-high, clk edge): FIFO empty, wr_ptr = rd_ptr = 0, beat_cnt = 0, outstanding = 0, err_rlast = 0.
- Outputs after reset: ar_ready = 0 if ARREADY = 0; ARVALID = 0 if ar_valid = 0; RREADY = 0; r_valid = 0; r_head = 0; r_tail = 0; r_tgtid = 0.
- Reset mid-burst discards all tracked entries. No flits are emitted for those entries after reset.
- full = (outstanding == DEPTH); empty = (outstanding == 0). Both are derived from registered state only.
- AR path (combinational):
  - ARVALID = ar_valid & !full
  - ar_ready = ARREADY & !full
  - push = ar_valid & ar_ready; writes {ar_srcid, ar_len} at wr_ptr; wr_ptr wraps modulo DEPTH.
- When full, the AR path stalls even if a pop happens in the same cycle. There is no bypass; the AR handshake resumes the next cycle.
- R path (combinational):
  - r_valid = RVALID & !empty
  - RREADY = r_ready & !empty
  - beat = RVALID & RREADY
- Head entry {h_src, h_len} is at rd_ptr.
  - r_tgtid = h_src
  - r_head = r_valid & (beat_cnt == 0)
  - r_tail = r_valid & (beat_cnt == h_len)
- Beat handling on each beat:
  - If tail: pop, rd_ptr wraps, beat_cnt <= 0.
  - Otherwise: beat_cnt <= beat_cnt + 1.
  - For a single-beat burst (h_len = 0), head and tail assert in the same flit.
- The tracked length, not RLAST, is authoritative for r_tail.
  - If a beat occurs with RLAST != (beat_cnt == h_len), err_rlast sets and holds until reset.
  - Sequencing still follows the counter.
- outstanding:
  - +1 on push only; -1 on pop only.
  - Unchanged when push and pop occur in the same cycle.
  - Never exceeds DEPTH and never underflows.
- A push into an empty FIFO becomes visible to the R path one cycle later. RVALID while empty is a protocol violation: RREADY stays 0 and the beat is held off.
- r_ready low stalls the R path. beat_cnt and the head entry hold, and head/tail/tgtid stay stable while r_valid is high.
- Latency: AR and R handshakes are zero-cycle pass-through; state updates take effect on the next clk edge.

Test Plan:
- Reset, then AR ar_srcid=2, ar_len=3 with ARREADY=1, then 4 R beats with RLAST on the 4th -> ARVALID=1 on the accept cycle, outstanding goes 0->1->0; flits show head=1 on beat 0 and tail=1 on beat 3, r_tgtid=2 throughout, err_rlast=0.
- Three single-beat ARs with srcids 0, 1, 3, then 3 R beats -> each flit has head=tail=1; r_tgtid sequence is 0, 1, 3.
- Push 4 ARs (DEPTH=4) with no R data, then assert a 5th ar_valid -> ar_ready=0 and ARVALID=0, outstanding=4. Complete one burst -> the 5th AR is accepted the cycle after the pop.
- Accept an AR in the same cycle as the final beat of the current burst with outstanding=2 -> outstanding stays 2; the next flit has head=1 with the new head entry's srcid.
- Burst ar_len=2 with RLAST asserted on beat 1 -> err_rlast=1 from the next cycle; r_tail still on beat 2; err_rlast stays 1 until rst.
- Mid-burst: toggle r_ready low for 3 cycles -> RREADY=0, flags stable. Then assert rst mid-burst -> outstanding=0, r_valid=0, and the next AR starts with a head flit.
